// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive definitions (FSM states, entry layout, length decode)
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BRK
    } state_t;
    localparam int ENTRY_W = 10;
    localparam int E_PERR  = 8;
    localparam int E_FERR  = 9;
    function automatic logic [3:0] char_bits(input logic [1:0] len);
        return {2'b00, len} + 4'd5;
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO with guarded push/pop and occupancy count
module uart_rx_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CNT_W'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];
    // storage needs no reset; the head is only meaningful while non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_engine_fifo.sv
// uart_rx_engine_fifo: oversampling UART receiver feeding a show-ahead FIFO; UART_RX_BREAK_DET_EN enables break detection
module uart_rx_engine_fifo
    import uart_pkg::*;
#(
    parameter int K_W        = 19,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic [K_W-1:0]   k,
    input  logic [1:0]       char_len,
    input  logic             p_en,
    input  logic             ohel,
    input  logic             two_stop,
    input  logic             read,
    input  logic             clr_ovf,
    output logic             rx_rdy,
    output logic [7:0]       data_out,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overflow,
    output logic             brk,
    output logic [CNT_W-1:0] fifo_count
);
    state_t             state, nxt;
    logic               s1, s2, prev;
    logic [K_W-1:0]     cnt;
    logic               btu, half, cnt_clr, start_ok, push, is_brk, full, empty;
    logic [7:0]         data;
    logic [3:0]         idx, nbits;
    logic               pen, odd, two, perr, ferr;
    logic [ENTRY_W-1:0] head;
    assign btu      = cnt == k;
    assign half     = cnt == (k >> 1);
    assign start_ok = state == S_START && half && !s2;
    // two-flop synchroniser plus history flop, idle-high after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {s1, s2, prev} <= 3'b111;
        else {s1, s2, prev} <= {rx, s1, s2};
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= nxt;
    end
    // next-state logic; all post-start samples land on btu, i.e. mid-bit
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = (prev && !s2) ? S_START : S_IDLE;
            S_START:  nxt = half ? (s2 ? S_IDLE : S_DATA) : S_START;
            S_DATA:   nxt = (btu && idx == nbits - 4'd1) ? (pen ? S_PARITY : S_STOP1) : S_DATA;
            S_PARITY: nxt = btu ? S_STOP1 : S_PARITY;
            S_STOP1:  nxt = btu ? (is_brk ? S_BRK : two ? S_STOP2 : S_PUSH) : S_STOP1;
            S_STOP2:  nxt = btu ? S_PUSH : S_STOP2;
            S_PUSH:   nxt = S_IDLE;
            S_BRK:    nxt = s2 ? S_IDLE : S_BRK;
            default:  nxt = S_IDLE;
        endcase
    end
    // FSM outputs: FIFO write strobe and bit-counter restart
    always_comb begin
        push    = state == S_PUSH;
        cnt_clr = state == S_IDLE || (state == S_START && half);
    end
    // bit-time counter 0..k, restarted at idle and at the validated start midpoint
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else cnt <= (cnt_clr || btu) ? '0 : cnt + K_W'(1);
    end
    // frame datapath: config latched at start, bits assembled LSB first, errors accumulated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {data, idx, nbits, pen, odd, two, perr, ferr} <= '0;
        end else if (start_ok) begin
            {data, idx, perr, ferr} <= '0;
            {nbits, pen, odd, two}  <= {char_bits(char_len), p_en, ohel, two_stop};
        end else if (btu) begin
            if (state == S_DATA) begin
                data[idx[2:0]] <= s2;
                idx            <= idx + 4'd1;
            end
            if (state == S_PARITY) perr <= ^data ^ s2 ^ odd;
            if (state == S_STOP1)  ferr <= !s2;
            if (state == S_STOP2)  ferr <= ferr | !s2;
        end
    end
`ifdef UART_RX_BREAK_DET_EN
    logic pbit;
    assign is_brk = data == '0 && !pbit && !s2;
    // received parity bit, kept so an all-zero frame including parity can be seen as a break
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pbit <= 1'b0;
        else if (start_ok) pbit <= 1'b0;
        else if (btu && state == S_PARITY) pbit <= s2;
    end
    // sticky break flag, cleared by read or clr_ovf; a new break wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) brk <= 1'b0;
        else brk <= (brk && !(read || clr_ovf)) || (state == S_STOP1 && btu && is_brk);
    end
`else
    assign is_brk = 1'b0;
    assign brk    = 1'b0;
`endif
    // sticky overflow: a push against a full FIFO not relieved by a same-cycle pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else overflow <= (overflow && !clr_ovf) || (push && full && !read);
    end
    uart_rx_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (read),
        .din   ({ferr, perr, data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    assign rx_rdy     = !empty;
    assign data_out   = rx_rdy ? head[7:0] : 8'h00;
    assign parity_err = rx_rdy && head[E_PERR];
    assign frame_err  = rx_rdy && head[E_FERR];
endmodule

// File: tb/tb_uart_rx_engine_fifo.sv
// tb_uart_rx_engine_fifo: directed self-checking bench for the UART receiver with FIFO
module tb_uart_rx_engine_fifo;
    localparam int BT = 109;
    logic        clk = 0, rst = 0, rx = 1, p_en = 0, ohel = 0, two_stop = 0, read = 0, clr_ovf = 0;
    logic [18:0] k = 19'd108;
    logic [1:0]  char_len = 2'b11;
    logic        rx_rdy, parity_err, frame_err, overflow, brk;
    logic [7:0]  data_out;
    logic [3:0]  fifo_count;
    int          checks = 0, errors = 0;

    uart_rx_engine_fifo dut (
        .clk(clk), .rst(rst), .rx(rx), .k(k), .char_len(char_len), .p_en(p_en),
        .ohel(ohel), .two_stop(two_stop), .read(read), .clr_ovf(clr_ovf),
        .rx_rdy(rx_rdy), .data_out(data_out), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow), .brk(brk), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tx_bit(input logic v);
        rx = v;
        repeat (BT) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int n, input logic has_par, input logic par,
                        input logic has_s2, input logic s2);
        tx_bit(1'b0);
        for (int i = 0; i < n; i++) tx_bit(d[i]);
        if (has_par) tx_bit(par);
        tx_bit(1'b1);
        if (has_s2) tx_bit(s2);
        rx = 1'b1;
    endtask

    task automatic pop();
        @(negedge clk) read = 1;
        @(negedge clk) read = 0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_ovf = 1;
        @(negedge clk) clr_ovf = 0;
    endtask

    task automatic pop_on_push();
        bit seen = 0;
        for (int i = 0; i < 3 * BT * 10 && !seen; i++) begin
            @(negedge clk);
            if (dut.push) begin
                seen = 1;
                read = 1;
                @(negedge clk) read = 0;
            end
        end
        chk("push_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rx_rdy), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_brk", 32'(brk), 0);
        chk("rst_cnt", 32'(fifo_count), 0);
        rst = 1;
        repeat (5) @(negedge clk);

        send(8'h55, 8, 0, 0, 0, 0);
        chk("8n1_rdy", 32'(rx_rdy), 1);
        chk("8n1_data", 32'(data_out), 32'h55);
        chk("8n1_perr", 32'(parity_err), 0);
        chk("8n1_ferr", 32'(frame_err), 0);
        chk("8n1_cnt", 32'(fifo_count), 1);
        pop();
        chk("8n1_rdy_pop", 32'(rx_rdy), 0);
        chk("8n1_data_pop", 32'(data_out), 0);

        char_len = 2'b10; p_en = 1; ohel = 0;
        send(8'h41, 7, 1, 1, 0, 0);
        chk("7e1_perr", 32'(parity_err), 1);
        chk("7e1_data", 32'(data_out), 32'h41);
        chk("7e1_ferr", 32'(frame_err), 0);
        pop();

        char_len = 2'b11; p_en = 0; two_stop = 1;
        send(8'hA3, 8, 0, 0, 1, 0);
        chk("8n2_ferr", 32'(frame_err), 1);
        chk("8n2_data", 32'(data_out), 32'hA3);
        chk("8n2_perr", 32'(parity_err), 0);
        pop();
        two_stop = 0;

        rx = 0;
        repeat (30) @(negedge clk);
        rx = 1;
        repeat (2 * BT) @(negedge clk);
        chk("glitch_cnt", 32'(fifo_count), 0);
        chk("glitch_rdy", 32'(rx_rdy), 0);

        for (int i = 1; i <= 9; i++) send(8'(i), 8, 0, 0, 0, 0);
        chk("ovf_cnt", 32'(fifo_count), 8);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head", 32'(data_out), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", 32'(data_out), 32'(i));
            pop();
        end
        chk("drain_cnt", 32'(fifo_count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        pulse_clr();
        chk("ovf_clr", 32'(overflow), 0);

        for (int i = 1; i <= 8; i++) send(8'(i), 8, 0, 0, 0, 0);
        fork
            send(8'h09, 8, 0, 0, 0, 0);
            pop_on_push();
        join
        chk("rw_ovf", 32'(overflow), 0);
        chk("rw_cnt", 32'(fifo_count), 8);
        chk("rw_head", 32'(data_out), 2);
        repeat (7) pop();
        chk("rw_last", 32'(data_out), 9);
        chk("rw_last_cnt", 32'(fifo_count), 1);
        pop();

        rx = 0;
        repeat (20 * BT) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_set", 32'(brk), 1);
        chk("brk_cnt", 32'(fifo_count), 0);
        rx = 1;
        repeat (2 * BT) @(negedge clk);
        pulse_clr();
        chk("brk_clr", 32'(brk), 0);
`else
        chk("brk_tied", 32'(brk), 0);
        chk("brk_cnt", 32'(fifo_count), 1);
        chk("brk_ferr", 32'(frame_err), 1);
        chk("brk_data", 32'(data_out), 0);
        pop();
        rx = 1;
        repeat (2 * BT) @(negedge clk);
`endif
        send(8'h5A, 8, 0, 0, 0, 0);
        chk("post_data", 32'(data_out), 32'h5A);
        chk("post_cnt", 32'(fifo_count), 1);
        chk("post_ferr", 32'(frame_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_engine_fifo.md
Name: uart_rx_engine_fifo

Overview:
Parametrised successor to the team's UART receive engine. Oversamples a serial rx line, frames characters of 5–8 data bits with optional parity and 1 or 2 stop bits, and validates the start bit at mid-bit. Each received character, with its per-character error flags, is pushed into an internal show-ahead FIFO. Sits between the pad-side rx pin and the processor-side UART register interface.

Parameters:
K_W, 19, width of bit-time divisor k
FIFO_DEPTH, 8, receive FIFO entries (power of 2, min 2)
CNT_W, 4, width of fifo_count (must hold FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rx  in  1  serial input, idle high, asynchronous to clk
k  in  K_W  clocks per bit minus 1 (e.g. 108 = 109 clk/bit)
char_len  in  2  00=5, 01=6, 10=7, 11=8 data bits
p_en  in  1  parity bit present
ohel  in  1  parity sense: 1=odd, 0=even
two_stop  in  1  expect two stop bits
read  in  1  pop head entry (one pop per cycle high)
clr_ovf  in  1  clears sticky overflow
rx_rdy  out  1  FIFO non-empty
data_out  out  8  head entry data, LSB-first reassembled, unused MSBs zero
parity_err  out  1  head entry parity error
frame_err  out  1  head entry stop-bit error
overflow  out  1  sticky: character dropped because FIFO full
brk  out  1  sticky break flag (see Optional Feature)
fifo_count  out  CNT_W  entries held

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM IDLE, FIFO empty, synchroniser flops preset to 1.
- rx passes a 2-FF synchroniser; a third flop holds the previous value for edge detection.
- Bit counter counts 0..k; btu asserts for one cycle when counter==k, then reloads 0. Half-bit tick at counter==k>>1.
- FSM: IDLE → START on synchronised falling edge (prev=1, cur=0); a constant-low line never retriggers.
- START: at half-bit, rx=1 → IDLE (false start, nothing pushed); rx=0 → counter cleared → DATA. All later samples taken on btu, i.e. mid-bit.
- DATA: shifts in char_len+5 bits LSB first → PARITY if p_en, else STOP1.
- PARITY: computed parity = XOR(data bits, received parity bit) ^ ohel; nonzero → parity_err for the entry.
- STOP1: rx=0 → frame_err. Then STOP2 if two_stop, else PUSH. STOP2 ORs its own check into frame_err.
- PUSH: one cycle; writes {frame_err, parity_err, data} to FIFO; → IDLE. rx_rdy rises the clock after PUSH.
- char_len, p_en, ohel, two_stop are sampled at the START→DATA transition and held for the frame.
- FIFO is show-ahead: data_out, parity_err and frame_err reflect the head entry whenever rx_rdy=1, else 0.
- read with FIFO empty: ignored.
- PUSH with FIFO full and no read: entry dropped, overflow set to 1.
- PUSH with FIFO full and read in the same cycle: pop and push both occur, count unchanged, no overflow.
- overflow stays set until clr_ovf; clr_ovf together with a new overflow event leaves overflow = 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end because full and empty are guarded.
- rst mid-frame: frame abandoned immediately, FIFO flushed.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined: a frame with all data bits 0, parity bit 0 (if p_en) and STOP1=0 is a break. The entry is not pushed and brk is set sticky. The FSM enters BRK_WAIT until synchronised rx=1, then returns to IDLE. brk clears on read or clr_ovf.
- Undefined: such a frame is pushed as a normal frame_err entry, and brk is tied 0.

Decomposition:
- Shared package/include uart_pkg: FSM state encodings, char_len decode function (len+5), FIFO entry width constant (10), entry bit positions.
- One sub-module: uart_rx_fifo (synchronous show-ahead FIFO with push, pop, full, empty, count), reusable by the transmit side.

Test Plan:
- k=108, 8N1, send 0x55 → after PUSH, rx_rdy=1, data_out=0x55, parity_err=0, frame_err=0, fifo_count=1; read → rx_rdy=0.
- 7E1 (char_len=10, p_en=1, ohel=0), send 0x41 with parity 1 → parity_err=1, data_out=0x41.
- 8N2, send 0xA3 with second stop bit 0 → frame_err=1.
- Low pulse of 30 clk on rx (k=108) → no push, FSM back in IDLE, fifo_count=0.
- Send 9 chars 0x01..0x09 without reads, FIFO_DEPTH=8 → fifo_count=8, overflow=1, head=0x01. Repeat with read asserted on the 9th PUSH cycle → overflow=0, last entry=0x09.
- Macro on: hold rx low for 20 bit times → brk=1, no entry, no re-trigger. rx high, then send 0x5A → received correctly.
